text_console_ctrl: RTL
======================

Name: text_console_ctrl

Overview:
- Character-stream controller driving the write port of the 80x25 text RAM (clk domain = RAM write clock).
- Accepts one byte per valid/ready handshake and keeps a cursor. Printable bytes become packed 32-bit word writes; newline, line wrap and clear-screen become timed RAM fill sequences.
- Replaces software word-packing by the CPU. Sits between the bus-side putchar register and the text RAM write port.

Parameters:
- COLS, 80, characters per row (multiple of 4)
- ROWS, 25, rows per screen
- BLANK, 8'h20, fill character for clears
- AW, 9, RAM word-address width (COLS*ROWS/4 = 500 words must fit)

Ports:
- clk  in  1  RAM write clock; all logic is on its rising edge
- resetn  in  1  asynchronous active-low reset
- in_data  in  8  character / control byte
- in_valid  in  1  byte offered
- in_ready  out  1  byte accepted when in_valid & in_ready
- write_address  out  AW  RAM word address
- write_data  out  32  RAM word; column lane = col%4, lane n at bits [8n+7:8n]
- write_en  out  1  one-cycle write strobe
- cursor_col  out  7  current column 0..COLS-1
- cursor_row  out  5  current row 0..ROWS-1
- busy  out  1  fill sequence in progress

Behaviour:
- Reset (async assert, sync release): write_en=0, write_address=0, write_data=0, cursor=(0,0), word buffer=4xBLANK, FSM=CLR_SCREEN with fill counter=0. busy=1 and in_ready=0 from reset until the first clear completes.
- Word buffer (wbuf, 32b) mirrors the RAM word containing the cursor. Every word entered by the cursor is known to be blank, so no read-back is needed.
- FSM states: IDLE, CLR_SCREEN, CLR_LINE.
- in_ready = (state==IDLE). busy = (state!=IDLE).
- IDLE, printable byte (0x20..0x7E or >=0x80, stored unmodified):
  - Cycle N: handshake; wbuf lane col%4 = byte.
  - Cycle N+1: write_en=1, write_address=(row*COLS+col)>>2, write_data=updated wbuf.
  - Also on the handshake edge: col increments.
  - If col%4 was 3, wbuf reloads to 4xBLANK.
  - If col was COLS-1 (auto-wrap): col=0; row=(row==ROWS-1)?0:row+1; go CLR_LINE for the new row.
- IDLE, LF (0x0A): col=0, row advances with the same wrap rule, wbuf=4xBLANK, go CLR_LINE. No write on the handshake cycle.
- IDLE, FF (0x0C): cursor=(0,0), wbuf=4xBLANK, go CLR_SCREEN.
- IDLE, any other byte (CR, other control codes, 0x7F): accepted in one cycle, no write, no cursor change.
- CLR_LINE:
  - COLS/4 consecutive cycles with write_en=1, write_data={4{BLANK}}, write_address=row*COLS/4 + k, k=0..COLS/4-1.
  - Returns to IDLE after the last write.
  - When entered by auto-wrap, the character write (cycle N+1) coincides with the handshake-cycle decision. Fill writes begin at N+2. The char write is never dropped.
- CLR_SCREEN: COLS*ROWS/4 writes, addresses 0..499 in order, data {4{BLANK}}, then IDLE.
- Write rate: at most one write per cycle. write_en is registered. write_address and write_data are stable in the same cycle as write_en.
- Address math: row*COLS computed in 11 bits, shifted right by 2. Must not exceed 499.
- Back-to-back printable bytes sustain 1 byte/cycle. A write is issued every cycle, and each word is written up to 4 times with cumulative contents.
- Reset mid-fill: the fill aborts, the state restarts as at reset, and a full clear is reissued.
- in_valid held low: no writes in IDLE. in_data is don't-care when in_valid=0.

Decomposition:
- Shared package text_pkg: COLS, ROWS, BLANK, control codes CH_LF=8'h0A, CH_FF=8'h0C, CH_CR=8'h0D, FSM state enum, WORDS=COLS*ROWS/4.
- Sub-module text_fill_seq (start, base address, word count -> address counter, write_en, done), shared by CLR_LINE and CLR_SCREEN.
- Cursor, wbuf and the FSM stay in the top module.

Test Plan:
- Reset release -> exactly 500 writes, addresses 0..499 ascending, data 32'h20202020, then in_ready=1, cursor (0,0).
- Send "ABCDE" back-to-back -> writes:
  - addr 0: 0x20202041, 0x20204241, 0x20434241, 0x44434241
  - addr 1: 0x20202045
  - cursor_col=5
- Send 'X' then LF -> one write at addr 0 (0x20202058). Then 20 writes at addresses 20..39 of 0x20202020. cursor (0,1); in_ready low for 20 cycles.
- Send 80 printable bytes with cursor at row 24 -> last char write at addr 499, then clear of addresses 0..19, cursor (0,0).
- FF after arbitrary text -> 500-write clear, cursor (0,0). CR and 0x07 -> no write_en, cursor unchanged.
- Assert resetn low midway through a CLR_LINE -> write_en=0 immediately, then a full 500-word clear after release.

Source files
------------

// File: rtl/text_pkg.sv
// text_pkg: shared constants, control codes and FSM states for the text console
package text_pkg;
  localparam int COLS = 80;
  localparam int ROWS = 25;
  localparam int AW = 9;
  localparam int WORDS = COLS * ROWS / 4;
  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;
  typedef enum logic [1:0] {IDLE, CLR_SCREEN, CLR_LINE} state_t;
endpackage

// File: rtl/text_console_ctrl_if.sv
// text_console_ctrl_if: byte stream handshake into the console controller
interface text_console_ctrl_if;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  modport master(output in_data, output in_valid, input in_ready);
  modport slave(input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/text_fill_seq.sv
// text_fill_seq: walks count consecutive word addresses from base, one per cycle
module text_fill_seq #(
  parameter int AW = 9,
  parameter int RST_COUNT = 500
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] count,
  output logic [AW-1:0] addr,
  output logic          we,
  output logic          done
);
  logic [AW-1:0] base_r, cnt_r, k;
  assign addr = base_r + k;
  assign done = we && (k == cnt_r - AW'(1));
  // Comes out of reset already running a full-screen sweep from address 0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we <= 1'b1;
      base_r <= '0;
      cnt_r <= AW'(RST_COUNT);
      k <= '0;
    end else if (start) begin
      we <= 1'b1;
      base_r <= base;
      cnt_r <= count;
      k <= '0;
    end else if (we) begin
      if (done) we <= 1'b0;
      else k <= k + AW'(1);
    end
  end
endmodule

// File: rtl/text_console_ctrl.sv
// text_console_ctrl: packs a byte stream into text RAM word writes with cursor, wrap and clears
module text_console_ctrl
  import text_pkg::*;
#(
  parameter int COLS = text_pkg::COLS,
  parameter int ROWS = text_pkg::ROWS,
  parameter logic [7:0] BLANK = text_pkg::BLANK,
  parameter int AW = text_pkg::AW
) (
  input  logic                 clk,
  input  logic                 resetn,
  text_console_ctrl_if.slave   s,
  output logic [AW-1:0]        write_address,
  output logic [31:0]          write_data,
  output logic                 write_en,
  output logic [6:0]           cursor_col,
  output logic [4:0]           cursor_row,
  output logic                 busy
);
  localparam int LW = $clog2(COLS * ROWS);
  localparam logic [AW-1:0] NWORDS = AW'(COLS * ROWS / 4);
  localparam logic [AW-1:0] LWORDS = AW'(COLS / 4);
  localparam logic [31:0] BLANK4 = {4{BLANK}};
  state_t state;
  logic [31:0] wbuf, nword;
  logic fire, printable, is_lf, is_ff, at_end, fill_start, fill_we, fill_done;
  logic [4:0] nrow;
  logic [LW-1:0] lin;
  logic [AW-1:0] fill_base, fill_count, fill_addr;
  assign s.in_ready = (state == IDLE);
  assign busy = (state != IDLE);
  assign fire = s.in_valid & s.in_ready;
  assign printable = (s.in_data >= 8'h20) && (s.in_data != 8'h7F);
  assign is_lf = (s.in_data == CH_LF);
  assign is_ff = (s.in_data == CH_FF);
  assign at_end = (cursor_col == 7'(COLS - 1));
  assign nrow = (cursor_row == 5'(ROWS - 1)) ? '0 : cursor_row + 5'd1;
  assign lin = LW'(cursor_row) * LW'(COLS) + LW'(cursor_col);
  assign fill_start = fire & (is_ff | is_lf | (printable & at_end));
  assign fill_base = is_ff ? '0 : AW'((LW'(nrow) * LW'(COLS)) >> 2);
  assign fill_count = is_ff ? NWORDS : LWORDS;
  // Cursor word with the incoming byte dropped into its lane
  always_comb begin
    nword = wbuf;
    nword[8*cursor_col[1:0] +: 8] = s.in_data;
  end
  text_fill_seq #(.AW(AW), .RST_COUNT(COLS * ROWS / 4)) u_fill (
    .clk(clk),
    .resetn(resetn),
    .start(fill_start),
    .base(fill_base),
    .count(fill_count),
    .addr(fill_addr),
    .we(fill_we),
    .done(fill_done)
  );
  // Main FSM: character writes and cursor moves in IDLE, fill writes otherwise
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= CLR_SCREEN;
      write_en <= 1'b0;
      write_address <= '0;
      write_data <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      wbuf <= BLANK4;
    end else if (state == IDLE) begin
      write_en <= fire & printable;
      if (fire & printable) begin
        write_address <= AW'(lin >> 2);
        write_data <= nword;
        wbuf <= (cursor_col[1:0] == 2'd3) ? BLANK4 : nword;
        cursor_col <= at_end ? '0 : cursor_col + 7'd1;
        if (at_end) begin
          cursor_row <= nrow;
          state <= CLR_LINE;
        end
      end else if (fire & is_lf) begin
        cursor_col <= '0;
        cursor_row <= nrow;
        wbuf <= BLANK4;
        state <= CLR_LINE;
      end else if (fire & is_ff) begin
        cursor_col <= '0;
        cursor_row <= '0;
        wbuf <= BLANK4;
        state <= CLR_SCREEN;
      end
    end else begin
      write_en <= fill_we;
      write_address <= fill_addr;
      write_data <= BLANK4;
      if (fill_done) state <= IDLE;
    end
  end
endmodule
